// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one DRAM request port among NUM_REQ requesters.
// One transaction in flight; out-of-range addresses are answered locally with an error strobe.
module mem_bus_arbiter #(
    parameter int          NUM_REQ            = 4,
    parameter int          SRC_W              = 3,
    parameter logic [63:0] END_MEMORY_ADDRESS = 64'd65536
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_is_write,
    input  logic [NUM_REQ*64-1:0]  req_address,
    input  logic [NUM_REQ*64-1:0]  req_payload,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic                   resp_error,
    output logic [63:0]            resp_data,
    output logic [63:0]            resp_address,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_is_write,
    output logic [63:0]            mem_req_address,
    output logic [63:0]            mem_req_payload,
    output logic [SRC_W-1:0]       mem_req_source,
    input  logic                   mem_resp_valid,
    input  logic [63:0]            mem_resp_data,
    input  logic [SRC_W-1:0]       mem_resp_source,
    input  logic [63:0]            mem_resp_address,
    output logic                   protocol_error
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [63:0] LAST_LEGAL = END_MEMORY_ADDRESS - 64'd8;

    logic [1:0]         state_reg;
    logic [SRC_W-1:0]   rr_ptr_reg;
    logic [SRC_W-1:0]   source_reg;
    logic               is_write_reg;
    logic [63:0]        address_reg;
    logic [63:0]        payload_reg;
    logic [NUM_REQ-1:0] resp_valid_reg;
    logic               resp_error_reg;
    logic [63:0]        resp_data_reg;
    logic [63:0]        resp_address_reg;
    logic               protocol_error_reg;

    logic [63:0] address_arr [NUM_REQ];
    logic [63:0] payload_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign address_arr[gi] = req_address[gi*64 +: 64];
            assign payload_arr[gi] = req_payload[gi*64 +: 64];
        end
    endgenerate

    logic               found;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W:0]     rot_idx;
    logic               win_is_write;
    logic [63:0]        win_address;
    logic [63:0]        win_payload;
    logic               grant;
    logic [SRC_W-1:0]   rr_ptr_next;

    // Walk the requesters starting at rr_ptr; the first valid one found wins.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        rot_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot_idx = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
            if (rot_idx >= (SRC_W+1)'(NUM_REQ))
                rot_idx = rot_idx - (SRC_W+1)'(NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req_valid[j] && rot_idx == (SRC_W+1)'(j)) begin
                    found  = 1'b1;
                    winner = SRC_W'(j);
                end
            end
        end
    end

    always_comb begin
        win_is_write = 1'b0;
        win_address  = '0;
        win_payload  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == SRC_W'(j)) begin
                win_is_write = req_is_write[j];
                win_address  = address_arr[j];
                win_payload  = payload_arr[j];
            end
        end
    end

    assign grant       = (state_reg == ST_IDLE) && found && !reset;
    assign rr_ptr_next = (winner == SRC_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++)
            req_ready[j] = grant && (winner == SRC_W'(j));
    end

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SRC_W-1:0] src);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_REQ; j++)
            v[j] = (src == SRC_W'(j));
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            rr_ptr_reg         <= '0;
            source_reg         <= '0;
            is_write_reg       <= 1'b0;
            address_reg        <= '0;
            payload_reg        <= '0;
            resp_valid_reg     <= '0;
            resp_error_reg     <= 1'b0;
            resp_data_reg      <= '0;
            resp_address_reg   <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            resp_valid_reg <= '0;
            resp_error_reg <= 1'b0;
            // Any response we are not waiting for is a DRAM-side protocol violation.
            if (mem_resp_valid && (state_reg != ST_WAIT || mem_resp_source != source_reg))
                protocol_error_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (grant) begin
                        source_reg   <= winner;
                        is_write_reg <= win_is_write;
                        address_reg  <= win_address;
                        payload_reg  <= win_payload;
                        rr_ptr_reg   <= rr_ptr_next;
                        if (win_address > LAST_LEGAL) begin
                            // Error strobe is visible during the ERR cycle.
                            state_reg      <= ST_ERR;
                            resp_valid_reg <= onehot(winner);
                            resp_error_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready)
                        state_reg <= is_write_reg ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_resp_valid && mem_resp_source == source_reg) begin
                        resp_valid_reg   <= onehot(source_reg);
                        resp_data_reg    <= mem_resp_data;
                        resp_address_reg <= mem_resp_address;
                        state_reg        <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid    = (state_reg == ST_ISSUE);
    assign mem_req_is_write = is_write_reg;
    assign mem_req_address  = address_reg;
    assign mem_req_payload  = payload_reg;
    assign mem_req_source   = source_reg;
    assign resp_valid       = resp_valid_reg;
    assign resp_error       = resp_error_reg;
    assign resp_data        = resp_data_reg;
    assign resp_address     = resp_address_reg;
    assign protocol_error   = protocol_error_reg;

endmodule
